mem_port_arb: RTL and testbench

MEM_PORT_ARB -- requirements
Module: mem_port_arb

---
 rtl/mem_pkg.sv | 27 ++
 rtl/lsu_align.sv | 73 +++++++
 rtl/mem_port_arb.sv | 190 +++++++++++++++++++
 tb/tb_mem_port_arb.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// Holds the RV32I load/store size encoding, the arbiter FSM state encoding
// and the byte-enable base masks used by the store path.
package mem_pkg;

  // RV32I load/store width encoding carried in funct3
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  // Arbiter FSM: at most one memory transaction outstanding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Byte-enable masks for lane 0; shifted into place by the store path
  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling for the data port.
// Store side: byte-enable generation and byte/half replication of write data.
// Load side: lane extraction from the returned word with sign or zero extension.
module lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_rep,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  function automatic logic [31:0] sext8(input logic signed [7:0] v);
    logic signed [31:0] w;
    w = v;
    return w;
  endfunction

  function automatic logic [31:0] sext16(input logic signed [15:0] v);
    logic signed [31:0] w;
    w = v;
    return w;
  endfunction

  // Store: place the enable mask on the addressed lane, replicate narrow data
  always_comb begin
    st_be        = BE_W;
    st_wdata_rep = st_wdata;
    case (st_size)
      2'b00: begin
        st_be        = BE_B << st_addr_lo;
        st_wdata_rep = {4{st_wdata[7:0]}};
      end
      2'b01: begin
        st_be        = BE_H << {st_addr_lo[1], 1'b0};
        st_wdata_rep = {2{st_wdata[15:0]}};
      end
      default: begin
        st_be        = BE_W;
        st_wdata_rep = st_wdata;
      end
    endcase
  end

  // Load: pick the addressed byte/half and extend it according to funct3
  always_comb begin
    ld_byte = ld_rdata[7:0];
    case (ld_addr_lo)
      2'd0: ld_byte = ld_rdata[7:0];
      2'd1: ld_byte = ld_rdata[15:8];
      2'd2: ld_byte = ld_rdata[23:16];
      2'd3: ld_byte = ld_rdata[31:24];
      default: ld_byte = ld_rdata[7:0];
    endcase
    ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (funct3_e'(ld_funct3))
      F3_B:    ld_data = sext8(ld_byte);
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_H:    ld_data = sext16(ld_half);
      F3_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_port_arb.sv
// Two-requester arbiter (instruction fetch, load/store) onto one memory port.
// Data normally wins; a starvation counter lets fetch in after MAX_DWIN
// consecutive data grants. One transaction outstanding: IDLE -> REQ -> RESP.
// Optional feature macro: MISALIGN_TRAP_EN -- misaligned data accesses are
// answered locally with d_err instead of being force-aligned.
module mem_port_arb
  import mem_pkg::*;
#(
  parameter int unsigned MAX_DWIN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_funct3,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_DWIN);

  state_e      state_p1;
  logic [3:0]  starve_cnt_p1;
  logic        owner_d_p1;
  logic [31:0] addr_p1;
  logic [1:0]  addr_lo_p1;
  logic        we_p1;
  logic [3:0]  be_p1;
  logic [31:0] wdata_p1;
  logic [2:0]  funct3_p1;

  logic        idle;
  logic        fetch_win;
  logic        data_win;
  logic [3:0]  st_be;
  logic [31:0] st_wdata_rep;
  logic [31:0] ld_data;

  // Arbitration: data first unless fetch has waited MAX_DWIN data grants
  always_comb begin
    idle      = (state_p1 == ST_IDLE) && !rst;
    fetch_win = if_req && (!d_req || (starve_cnt_p1 == MAX_CNT));
    data_win  = d_req && !fetch_win;
  end

  assign if_gnt    = idle && fetch_win;
  assign d_gnt     = idle && data_win;

  assign mem_req   = (state_p1 == ST_REQ);
  assign mem_we    = we_p1;
  assign mem_addr  = addr_p1;
  assign mem_be    = be_p1;
  assign mem_wdata = wdata_p1;

  lsu_align u_lsu_align (
    .st_size      (d_funct3[1:0]),
    .st_addr_lo   (d_addr[1:0]),
    .st_wdata     (d_wdata),
    .st_be        (st_be),
    .st_wdata_rep (st_wdata_rep),
    .ld_funct3    (funct3_p1),
    .ld_addr_lo   (addr_lo_p1),
    .ld_rdata     (mem_rdata),
    .ld_data      (ld_data)
  );

`ifdef MISALIGN_TRAP_EN
  logic misaligned;

  // Half accesses need addr[0]=0, word accesses need addr[1:0]=0
  always_comb begin
    misaligned = 1'b0;
    case (d_funct3[1:0])
      2'b01:   misaligned = d_addr[0];
      2'b10:   misaligned = |d_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end
`else
  assign d_err = 1'b0;
`endif

  // Starvation counter: counts data grants that overtook a waiting fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_p1 <= 4'd0;
    end else if (idle) begin
      if (if_gnt || !if_req) begin
        starve_cnt_p1 <= 4'd0;
      end else if (d_gnt) begin
        starve_cnt_p1 <= starve_cnt_p1 + 4'd1;
      end
    end
  end

  // Transaction FSM: latch the winner, hold the memory request, return data
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1   <= ST_IDLE;
      owner_d_p1 <= 1'b0;
      addr_p1    <= 32'd0;
      addr_lo_p1 <= 2'd0;
      we_p1      <= 1'b0;
      be_p1      <= 4'd0;
      wdata_p1   <= 32'd0;
      funct3_p1  <= 3'd0;
      if_rvalid  <= 1'b0;
      if_rdata   <= 32'd0;
      d_rvalid   <= 1'b0;
      d_rdata    <= 32'd0;
`ifdef MISALIGN_TRAP_EN
      d_err      <= 1'b0;
`endif
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      d_err     <= 1'b0;
`endif
      case (state_p1)
        ST_IDLE: begin
          if (fetch_win) begin
            owner_d_p1 <= 1'b0;
            addr_p1    <= {if_addr[31:2], 2'b00};
            addr_lo_p1 <= if_addr[1:0];
            we_p1      <= 1'b0;
            be_p1      <= BE_W;
            wdata_p1   <= 32'd0;
            funct3_p1  <= F3_W;
            state_p1   <= ST_REQ;
          end else if (data_win) begin
`ifdef MISALIGN_TRAP_EN
            if (misaligned) begin
              d_rvalid <= 1'b1;
              d_err    <= 1'b1;
              d_rdata  <= 32'd0;
            end else
`endif
            begin
              owner_d_p1 <= 1'b1;
              addr_p1    <= {d_addr[31:2], 2'b00};
              addr_lo_p1 <= d_addr[1:0];
              we_p1      <= d_we;
              be_p1      <= st_be;
              wdata_p1   <= st_wdata_rep;
              funct3_p1  <= d_funct3;
              state_p1   <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            state_p1 <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (mem_rvalid) begin
            state_p1 <= ST_IDLE;
            if (owner_d_p1) begin
              d_rvalid <= 1'b1;
              d_rdata  <= ld_data;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end
        end
        default: state_p1 <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: a small word memory responds on the shared port
// with configurable grant/response delays; a table of directed load/store
// records is applied in a loop, followed by hand-written arbitration, stall
// and mid-transaction reset sequences. Expectations follow MISALIGN_TRAP_EN.
module tb_mem_port_arb;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [31:0] rdata;
    logic        chk_rd;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [2:0]  d_funct3;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        auto_resp = 1'b1;
  logic        m_gnt = 1'b0, m_rvalid = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  logic        r_gnt = 1'b0, r_rvalid = 1'b0;
  logic [31:0] r_rdata = 32'd0;
  int          gnt_delay = 0, rv_delay = 0;

  logic [31:0] mem [0:15] = '{32'h0000F400, 32'h80017F80, 32'd0, 32'd0, 32'd0, 32'd0,
                              32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                              32'd0, 32'd0};
  int          req_total = 0;
  int          gnt_wait = 0, rv_wait = 0;
  bit          pend = 1'b0;
  logic [31:0] cap_addr = 32'd0, cap_wdata = 32'd0;
  logic [3:0]  cap_be = 4'd0;

  bit          log_en = 1'b0;
  int          gcount = 0;
  logic [31:0] gpat = 32'd0;

  int n_vec = 0;
  int n_bad = 0;
  vec_t vecs[$];

  assign mem_gnt    = auto_resp ? r_gnt    : m_gnt;
  assign mem_rvalid = auto_resp ? r_rvalid : m_rvalid;
  assign mem_rdata  = auto_resp ? r_rdata  : m_rdata;

  always #5 clk = ~clk;

  mem_port_arb #(.MAX_DWIN(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  // Memory responder model
  always @(negedge clk) begin
    r_gnt    = 1'b0;
    r_rvalid = 1'b0;
    if (auto_resp) begin
      if (mem_req) begin
        req_total++;
        if (gnt_wait >= gnt_delay) begin
          r_gnt     = 1'b1;
          gnt_wait  = 0;
          cap_addr  = mem_addr;
          cap_be    = mem_be;
          cap_wdata = mem_wdata;
          if (mem_we) begin
            for (int b = 0; b < 4; b++)
              if (mem_be[b]) mem[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
          end
          pend    = 1'b1;
          rv_wait = 0;
        end else begin
          gnt_wait++;
        end
      end else if (pend) begin
        if (rv_wait >= rv_delay) begin
          r_rvalid = 1'b1;
          r_rdata  = mem[cap_addr[5:2]];
          pend     = 1'b0;
        end else begin
          rv_wait++;
        end
      end
    end
  end

  // Grant order recorder (bit i set when grant i went to fetch)
  always @(posedge clk) begin
    if (log_en && gcount < 32) begin
      if (if_gnt) begin gpat[gcount] = 1'b1; gcount++; end
      else if (d_gnt) begin gcount++; end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] mwdata,
                              input logic [31:0] rdata, input logic chk_rd, input logic err);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.be = be;
    v.mwdata = mwdata; v.rdata = rdata; v.chk_rd = chk_rd; v.err = err;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    bit got;
    int req_start;
    got = 1'b0;
    req_start = req_total;
    @(negedge clk);
    d_req = 1'b1; d_we = v.we; d_funct3 = v.f3; d_addr = v.addr; d_wdata = v.wdata;
    #1 check($sformatf("v%0d_gnt", idx), 32'(d_gnt), 32'd1);
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (d_rvalid) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check($sformatf("v%0d_rvalid_seen", idx), 32'(got), 32'd1);
    if (got) begin
      if (v.chk_rd) check($sformatf("v%0d_rdata", idx), d_rdata, v.rdata);
      check($sformatf("v%0d_err", idx), 32'(d_err), 32'(v.err));
      if (v.err) check($sformatf("v%0d_no_mem_req", idx), 32'(req_total - req_start), 32'd0);
      else       check($sformatf("v%0d_mem_addr", idx), cap_addr, {v.addr[31:2], 2'b00});
      if (v.we && !v.err) begin
        check($sformatf("v%0d_be", idx), 32'(cap_be), 32'(v.be));
        check($sformatf("v%0d_wdata", idx), cap_wdata, v.mwdata);
      end
      @(posedge clk); #1;
      check($sformatf("v%0d_rvalid_pulse", idx), 32'(d_rvalid), 32'd0);
    end
  endtask

  task automatic run_fetch(input logic [31:0] addr, input logic [31:0] exp, input string name);
    bit got;
    got = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = addr;
    #1 check({name, "_gnt"}, 32'(if_gnt), 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (if_rvalid) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check({name, "_rvalid_seen"}, 32'(got), 32'd1);
    if (got) check({name, "_rdata"}, if_rdata, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    int nreq, npulse, bad, nrv;
    logic [31:0] rd;
    rst = 1'b1; if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'd0; d_wdata = 32'd0; d_funct3 = 3'd0;

    vecs.push_back(mk(0, LB,  32'h01, 0, 0, 0, 32'hFFFFFFF4, 1, 0));
    vecs.push_back(mk(0, LBU, 32'h01, 0, 0, 0, 32'h000000F4, 1, 0));
    vecs.push_back(mk(0, LW,  32'h00, 0, 0, 0, 32'h0000F400, 1, 0));
    vecs.push_back(mk(0, LH,  32'h00, 0, 0, 0, 32'hFFFFF400, 1, 0));
    vecs.push_back(mk(0, LHU, 32'h00, 0, 0, 0, 32'h0000F400, 1, 0));
    vecs.push_back(mk(0, LB,  32'h05, 0, 0, 0, 32'h0000007F, 1, 0));
    vecs.push_back(mk(0, LB,  32'h04, 0, 0, 0, 32'hFFFFFF80, 1, 0));
    vecs.push_back(mk(0, LH,  32'h06, 0, 0, 0, 32'hFFFF8001, 1, 0));
    vecs.push_back(mk(0, LHU, 32'h06, 0, 0, 0, 32'h00008001, 1, 0));
    vecs.push_back(mk(1, LB,  32'h0B, 32'h000000AB, 4'b1000, 32'hABABABAB, 0, 0, 0));
    vecs.push_back(mk(0, LW,  32'h08, 0, 0, 0, 32'hAB000000, 1, 0));
    vecs.push_back(mk(1, LH,  32'h0A, 32'h00001234, 4'b1100, 32'h12341234, 0, 0, 0));
    vecs.push_back(mk(0, LW,  32'h08, 0, 0, 0, 32'h12340000, 1, 0));
    vecs.push_back(mk(1, LW,  32'h0C, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 0, 0, 0));
    vecs.push_back(mk(0, LW,  32'h0C, 0, 0, 0, 32'hDEADBEEF, 1, 0));
    vecs.push_back(mk(1, LB,  32'h10, 32'h12345655, 4'b0001, 32'h55555555, 0, 0, 0));
    vecs.push_back(mk(0, LBU, 32'h10, 0, 0, 0, 32'h00000055, 1, 0));
`ifdef MISALIGN_TRAP_EN
    vecs.push_back(mk(0, LW,  32'h02, 0, 0, 0, 32'h00000000, 1, 1));
    vecs.push_back(mk(0, LH,  32'h01, 0, 0, 0, 32'h00000000, 1, 1));
    vecs.push_back(mk(1, LH,  32'h13, 32'h0000BEEF, 0, 0, 32'h00000000, 1, 1));
`else
    vecs.push_back(mk(0, LW,  32'h02, 0, 0, 0, 32'h0000F400, 1, 0));
    vecs.push_back(mk(0, LH,  32'h01, 0, 0, 0, 32'hFFFFF400, 1, 0));
    vecs.push_back(mk(1, LH,  32'h13, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF, 0, 0, 0));
`endif
    vecs.push_back(mk(0, LW,  32'h04, 0, 0, 0, 32'h80017F80, 1, 0));

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    if_req = 1'b1; d_req = 1'b1;
    #1;
    check("rst_if_gnt", 32'(if_gnt), 32'd0);
    check("rst_d_gnt", 32'(d_gnt), 32'd0);
    if_req = 1'b0; d_req = 1'b0;
    check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    check("rst_d_err", 32'(d_err), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_fetch(32'h00, 32'h0000F400, "fetch0");

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Both requesters held high: D,D,D,D,F,D,D,D,D,F
    @(negedge clk);
    log_en = 1'b1;
    if_req = 1'b1; if_addr = 32'h04;
    d_req = 1'b1; d_we = 1'b0; d_funct3 = LW; d_addr = 32'h00;
    for (int i = 0; i < 200 && gcount < 10; i++) begin @(posedge clk); #1; end
    if_req = 1'b0; d_req = 1'b0;
    log_en = 1'b0;
    check("starve_grant_count", 32'(gcount >= 10), 32'd1);
    check("starve_grant_order", gpat & 32'h3FF, 32'h00000210);
    repeat (6) begin @(posedge clk); #1; end

    // Stalled fetch: fields stable during stall, single if_rvalid pulse
    gnt_delay = 3; rv_delay = 3;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h47;
    #1 check("stall_gnt", 32'(if_gnt), 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
    nreq = 0; npulse = 0; bad = 0; rd = 32'd0;
    for (int i = 0; i < 16; i++) begin
      if (mem_req) begin
        nreq++;
        if (mem_addr !== 32'h44 || mem_we !== 1'b0 || mem_be !== 4'hF) bad++;
      end
      if (if_rvalid) begin npulse++; rd = if_rdata; end
      @(posedge clk); #1;
    end
    check("stall_req_cycles", 32'(nreq), 32'd4);
    check("stall_fields_stable", 32'(bad), 32'd0);
    check("stall_rvalid_pulses", 32'(npulse), 32'd1);
    check("stall_rdata", rd, 32'h80017F80);
    gnt_delay = 0; rv_delay = 0;

    // Reset in RESP, late mem_rvalid afterwards
    auto_resp = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h04;
    @(posedge clk); #1;
    if_req = 1'b0;
    check("rstmid_mem_req", 32'(mem_req), 32'd1);
    @(negedge clk); m_gnt = 1'b1;
    @(posedge clk); #1;
    nrv = 0;
    @(negedge clk); m_gnt = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    nrv += int'(if_rvalid) + int'(d_rvalid);
    @(negedge clk); rst = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    nrv += int'(if_rvalid) + int'(d_rvalid);
    @(negedge clk); m_rvalid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      nrv += int'(if_rvalid) + int'(d_rvalid);
    end
    check("rstmid_no_rvalid", 32'(nrv), 32'd0);
    check("rstmid_mem_req_low", 32'(mem_req), 32'd0);
    check("rstmid_if_rdata", if_rdata, 32'd0);
    auto_resp = 1'b1;
    run_fetch(32'h04, 32'h80017F80, "post_rst_fetch");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
